// File: rtl/prince_axis_frame_builder_if.sv
// rtl/prince_axis_frame_builder_if.sv - pair input port and AXI-Stream output port of the frame builder
interface prince_axis_frame_builder_if #(
  parameter int DATA_SIZE = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [63:0]          in_plaintext;
  logic [127:0]         in_key;
  logic                 m_axis_tvalid;
  logic                 m_axis_tready;
  logic [DATA_SIZE-1:0] m_axis_tdata;
  logic                 m_axis_tlast;

  modport master (
    input  in_valid, in_plaintext, in_key, m_axis_tready,
    output in_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );

  modport slave (
    output in_valid, in_plaintext, in_key, m_axis_tready,
    input  in_ready, m_axis_tvalid, m_axis_tdata, m_axis_tlast
  );
endinterface

// File: rtl/prince_axis_frame_builder.sv
// rtl/prince_axis_frame_builder.sv - serializes plaintext+key pairs into 6-word PRINCE stream frames
// Define PRINCE_FRAME_DBUF_EN for a pending frame register (gapless back-to-back frames).
module prince_axis_frame_builder #(
  parameter int DATA_SIZE   = 32,
  parameter int FRAME_WORDS = 6
) (
  input  logic                        aclk,
  input  logic                        areset,
  prince_axis_frame_builder_if.master bus,
  output logic                        busy,
  output logic [15:0]                 frame_count
);
  localparam int         FRAME_BITS = DATA_SIZE * FRAME_WORDS;
  localparam logic [2:0] LAST_IDX   = 3'(FRAME_WORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic [15:0]           count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  accept, handshake, last_hs;
  logic [DATA_SIZE-1:0]  word;
  logic [FRAME_BITS-1:0] in_frame;
`ifdef PRINCE_FRAME_DBUF_EN
  logic [FRAME_BITS-1:0] pend_q, pend_d;
  logic                  pend_full_q, pend_full_d;
`endif

  // ready_q is the registered "can accept" flag; reset forces the port low in the reset cycle itself
  assign bus.in_ready = ready_q & ~areset;
  assign accept       = bus.in_valid & bus.in_ready;
  assign handshake    = (state_q == SEND) & bus.m_axis_tready;
  assign last_hs      = handshake & (idx_q == LAST_IDX);
  assign in_frame     = {bus.in_plaintext, bus.in_key};

  always_comb begin
    word = '0;
    for (int i = 0; i < FRAME_WORDS; i++) begin
      if (idx_q == i[2:0]) word = frame_q[FRAME_BITS-1-DATA_SIZE*i -: DATA_SIZE];
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    count_d = count_q;
`ifdef PRINCE_FRAME_DBUF_EN
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          frame_d = in_frame;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (last_hs) begin
          count_d = count_q + 16'd1;
          idx_d   = 3'd0;
`ifdef PRINCE_FRAME_DBUF_EN
          // Pending frame wins; otherwise a same-edge accept bypasses the pending register
          if (pend_full_q) begin
            frame_d     = pend_q;
            pend_full_d = 1'b0;
          end else if (accept) begin
            frame_d = in_frame;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          if (handshake) idx_d = idx_q + 3'd1;
`ifdef PRINCE_FRAME_DBUF_EN
          if (accept) begin
            pend_d      = in_frame;
            pend_full_d = 1'b1;
          end
`endif
        end
      end
    endcase
`ifdef PRINCE_FRAME_DBUF_EN
    ready_d = ~pend_full_d;
`else
    ready_d = (state_d == IDLE);
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      frame_q <= '0;
      count_q <= 16'd0;
      ready_q <= 1'b1;
`ifdef PRINCE_FRAME_DBUF_EN
      pend_q      <= '0;
      pend_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      count_q <= count_d;
      ready_q <= ready_d;
`ifdef PRINCE_FRAME_DBUF_EN
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
`endif
    end
  end

  assign bus.m_axis_tvalid = (state_q == SEND);
  assign bus.m_axis_tlast  = (state_q == SEND) & (idx_q == LAST_IDX);
  assign bus.m_axis_tdata  = (state_q == SEND) ? word : '0;
  assign frame_count       = count_q;
`ifdef PRINCE_FRAME_DBUF_EN
  assign busy = (state_q == SEND) | pend_full_q;
`else
  assign busy = (state_q == SEND);
`endif
endmodule
